uart_frame_assembler: RTL and testbench
=======================================

// Module: uart_frame_assembler
// PURPOSE
//  Sits between the UART receiver and the operand consumer (AND core / FSM).
//  Packs a stream of received bytes (RxData qualified by RxDone) into one
//  M-bit operand frame, guards against stalled links with an inter-byte
//  timeout, and holds the frame under a valid/consume handshake.
// PARAMETERS
//  M           16     operand frame width in bits; BYTES = (M+7)/8 (localparam)
//  TIMEOUT_CYC 40000  max Clk cycles between bytes inside a frame (10 ms @ 4 MHz)
// PORTS
//  Clk        in   1  system clock (4 MHz domain)
//  Rst_n      in   1  asynchronous reset, active-low
//  RxData     in   8  received byte, valid only in the RxDone cycle
//  RxDone     in   1  1-cycle pulse per received byte
//  Consume    in   1  downstream accepts the frame (sampled only while FrameValid=1)
//  FrameData  out  M  assembled operand, first byte in bits [7:0]
//  FrameValid out  1  frame complete and held stable
//  FrameErr   out  1  1-cycle error pulse
//  Busy       out  1  high in COLLECT (and CHECK when enabled)
// BEHAVIOUR
//  - Reset: FrameData=0, FrameValid=0, FrameErr=0, Busy=0, byte count=0,
//    timeout counter=0, state=IDLE. Reset mid-frame discards all partial data.
//  - Byte k (0-based) is written to FrameData[8k+7:8k]; bits of the last byte
//    above M-1 are dropped. Bytes not yet received read as 0 (cleared on frame start).
//  - States:
//    IDLE    : RxDone -> store byte 0, count=1, go COLLECT (or VALID if BYTES==1).
//    COLLECT : RxDone -> store byte, count++, timeout counter cleared.
//              When the BYTES-th byte is stored -> VALID (CHECK if checksum on).
//              No RxDone for TIMEOUT_CYC consecutive cycles -> FrameErr pulse,
//              clear count/data, go IDLE.
//    VALID   : FrameValid=1, FrameData frozen. Consume -> FrameValid=0 next cycle,
//              go IDLE. RxDone without Consume -> byte dropped, FrameErr pulse,
//              stay VALID (overrun). RxDone and Consume in the same cycle ->
//              frame consumed and that byte becomes byte 0 of a new frame (COLLECT).
//  - Latency: FrameValid rises the cycle after the RxDone of the final byte.
//  - Timeout counter saturates; it counts only in COLLECT/CHECK, held at 0 elsewhere.
//  - FrameErr is never asserted on two consecutive cycles from a single event.
// CONFIGURATION
//  FRAME_CHKSUM_EN defined: after BYTES data bytes the state is CHECK; the next
//    byte is a checksum that must equal XOR of all data bytes. Match -> VALID.
//    Mismatch -> FrameErr pulse, data cleared, IDLE. Timeout applies in CHECK.
//  FRAME_CHKSUM_EN undefined: no CHECK state; frame completes on the BYTES-th
//    byte; no XOR logic is synthesised.
// TESTING
//  1 M=16: RxDone bytes 0x34,0x12, Consume held 0 -> FrameValid=1 the cycle after
//    the 2nd RxDone, FrameData=16'h1234, Busy=0; Consume=1 -> FrameValid=0 next cycle.
//  2 M=12: bytes 0xAB,0xFC -> FrameData=12'hCAB (upper nibble of byte 1 dropped).
//  3 Byte 0x55, then TIMEOUT_CYC idle cycles -> one FrameErr pulse, Busy=0;
//    bytes 0x01,0x02 -> FrameData=16'h0201 (no stale data).
//  4 In VALID with 16'h1234: RxDone 0x99 without Consume -> FrameErr pulse,
//    FrameData still 16'h1234; then RxDone 0x77 with Consume -> COLLECT, byte0=0x77.
//  5 Assert Rst_n=0 asynchronously after one byte of a frame -> all outputs 0
//    immediately; after release, a fresh 2-byte frame assembles correctly.
//  6 FRAME_CHKSUM_EN: bytes 0x34,0x12,0x26 -> VALID 16'h1234; bytes 0x34,0x12,0x00
//    -> FrameErr pulse, FrameValid stays 0, state IDLE.

Source files
------------

// File: rtl/uart_frame_assembler.sv
// Packs RxDone-qualified UART bytes into an M-bit operand frame with inter-byte timeout
// and valid/consume handoff. Define FRAME_CHKSUM_EN to require a trailing XOR checksum byte.
module uart_frame_assembler #(
  parameter int M           = 16,
  parameter int TIMEOUT_CYC = 40000
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic [7:0]   RxData,
  input  logic         RxDone,
  input  logic         Consume,
  output logic [M-1:0] FrameData,
  output logic         FrameValid,
  output logic         FrameErr,
  output logic         Busy
);

  localparam int BYTES = (M + 7) / 8;
  localparam int CW    = $clog2(BYTES + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

`ifdef FRAME_CHKSUM_EN
  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, VALID} state_t;
  localparam state_t DONE_ST = CHECK;
  logic [7:0] chk, chk_n;
`else
  typedef enum logic [1:0] {IDLE, COLLECT, VALID} state_t;
  localparam state_t DONE_ST = VALID;
`endif

  state_t        state, state_n;
  logic [M-1:0]  data, data_n;
  logic [CW-1:0] cnt, cnt_n, wr_idx;
  logic [TW-1:0] tmo, tmo_n;
  logic          err_n, start, wr;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      data  <= '0;
      cnt   <= '0;
      tmo   <= '0;
      FrameErr <= 1'b0;
`ifdef FRAME_CHKSUM_EN
      chk   <= '0;
`endif
    end else begin
      state <= state_n;
      data  <= data_n;
      cnt   <= cnt_n;
      tmo   <= tmo_n;
      FrameErr <= err_n;
`ifdef FRAME_CHKSUM_EN
      chk   <= chk_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    data_n  = data;
    cnt_n   = cnt;
    tmo_n   = '0;
    err_n   = 1'b0;
    start   = 1'b0;
    wr      = 1'b0;
`ifdef FRAME_CHKSUM_EN
    chk_n   = chk;
`endif
    case (state)
      IDLE: if (RxDone) start = 1'b1;
      COLLECT: begin
        if (RxDone) begin
          wr    = 1'b1;
          cnt_n = cnt + 1'b1;
          if (cnt == LAST_IDX) state_n = DONE_ST;
        end else if (tmo == TMO_LAST) begin
          err_n   = 1'b1;
          data_n  = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
`ifdef FRAME_CHKSUM_EN
      CHECK: begin
        if (RxDone) begin
          if (RxData == chk) begin
            state_n = VALID;
          end else begin
            err_n   = 1'b1;
            data_n  = '0;
            cnt_n   = '0;
            state_n = IDLE;
          end
        end else if (tmo == TMO_LAST) begin
          err_n   = 1'b1;
          data_n  = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
`endif
      VALID: begin
        if (Consume) begin
          state_n = IDLE;
          cnt_n   = '0;
          if (RxDone) start = 1'b1;
        end else if (RxDone) begin
          err_n = 1'b1;  // overrun: byte dropped, frame kept intact
        end
      end
      default: state_n = IDLE;
    endcase

    // A new frame clears stale bytes so short frames never leak old data.
    if (start) begin
      data_n  = '0;
      cnt_n   = CW'(1);
      wr      = 1'b1;
      state_n = (BYTES == 1) ? DONE_ST : COLLECT;
    end
    wr_idx = start ? '0 : cnt;

`ifdef FRAME_CHKSUM_EN
    if (start)   chk_n = RxData;
    else if (wr) chk_n = chk ^ RxData;
`endif

    // Bits of the last byte above M-1 simply have no destination.
    if (wr) begin
      for (int i = 0; i < M; i++) begin
        if ((i / 8) == int'(wr_idx)) data_n[i] = RxData[i % 8];
      end
    end
  end

  assign FrameData  = data;
  assign FrameValid = (state == VALID);
`ifdef FRAME_CHKSUM_EN
  assign Busy = (state == COLLECT) || (state == CHECK);
`else
  assign Busy = (state == COLLECT);
`endif

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench for uart_frame_assembler: an M=16 and an M=12 instance share stimulus.
module tb_uart_frame_assembler;
  localparam int T = 50;

  logic        Clk = 1'b0, Rst_n = 1'b0, RxDone = 1'b0, Consume = 1'b0;
  logic [7:0]  RxData = 8'h00;
  logic [15:0] data16;
  logic [11:0] data12;
  logic        v16, e16, b16, v12, e12, b12;
  int          checks = 0, errors = 0;
  logic [15:0] exp_q[$];

  always #5 Clk = ~Clk;

  uart_frame_assembler #(.M(16), .TIMEOUT_CYC(T)) u16 (
    .Clk(Clk), .Rst_n(Rst_n), .RxData(RxData), .RxDone(RxDone), .Consume(Consume),
    .FrameData(data16), .FrameValid(v16), .FrameErr(e16), .Busy(b16));

  uart_frame_assembler #(.M(12), .TIMEOUT_CYC(T)) u12 (
    .Clk(Clk), .Rst_n(Rst_n), .RxData(RxData), .RxDone(RxDone), .Consume(Consume),
    .FrameData(data12), .FrameValid(v12), .FrameErr(e12), .Busy(b12));

  task automatic drive_byte(input logic [7:0] b, input logic cons);
    @(negedge Clk);
    RxData = b; RxDone = 1'b1; Consume = cons;
    @(negedge Clk);
    RxDone = 1'b0; Consume = 1'b0; RxData = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1);
    exp_q.push_back({b1, b0});
    drive_byte(b0, 1'b0);
    drive_byte(b1, 1'b0);
`ifdef FRAME_CHKSUM_EN
    drive_byte(b0 ^ b1, 1'b0);
`endif
  endtask

  task automatic expect_frame(input string name);
    logic [15:0] e;
    int n;
    n = 0;
    while (v16 !== 1'b1 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
    checks++;
    if (v16 !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: FrameValid=%b after %0d cycles, required 1", name, v16, n);
    end
    checks++;
    if (data16 !== e) begin
      errors++;
      $display("FAIL %s_data: FrameData=%h required %h", name, data16, e);
    end
  endtask

  task automatic consume(input string name);
    @(negedge Clk);
    Consume = 1'b1;
    @(negedge Clk);
    Consume = 1'b0;
    checks++;
    if (v16 !== 1'b0 || v12 !== 1'b0) begin
      errors++;
      $display("FAIL %s_consume: FrameValid=%b/%b required 0/0", name, v16, v12);
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({v16, e16, b16, v12, e12, b12} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: v/e/b=%b%b%b %b%b%b required all 0", v16, e16, b16, v12, e12, b12);
    end
    checks++;
    if (data16 !== 16'h0 || data12 !== 12'h0) begin
      errors++;
      $display("FAIL reset_data: FrameData=%h/%h required 0/0", data16, data12);
    end
    Rst_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_basic;
    exp_q.push_back(16'h1234);
    drive_byte(8'h34, 1'b0);
    checks++;
    if (v16 !== 1'b0 || b16 !== 1'b1) begin
      errors++;
      $display("FAIL basic_mid: valid=%b busy=%b required 0 1", v16, b16);
    end
    drive_byte(8'h12, 1'b0);
`ifdef FRAME_CHKSUM_EN
    drive_byte(8'h26, 1'b0);
`endif
    checks++;
    if (v16 !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: FrameValid=%b one cycle after last byte, required 1", v16);
    end
    expect_frame("basic");
    checks++;
    if (b16 !== 1'b0 || e16 !== 1'b0) begin
      errors++;
      $display("FAIL basic_flags: busy=%b err=%b required 0 0", b16, e16);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (v16 !== 1'b1 || data16 !== 16'h1234) begin
      errors++;
      $display("FAIL basic_hold: valid=%b data=%h required 1 1234", v16, data16);
    end
    consume("basic");
  endtask

  task automatic test_m12;
    send_frame(8'hAB, 8'hFC);
    expect_frame("m12");
    checks++;
    if (v12 !== 1'b1 || data12 !== 12'hCAB) begin
      errors++;
      $display("FAIL m12_trunc: valid=%b data=%h required 1 cab", v12, data12);
    end
    consume("m12");
  endtask

  task automatic test_timeout;
    int bad;
    bad = 0;
    drive_byte(8'h55, 1'b0);
    for (int k = 1; k < T; k++) begin
      @(negedge Clk);
      if (e16 !== 1'b0 || b16 !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timeout_early: %0d bad cycles before limit, required 0", bad);
    end
    @(negedge Clk);
    checks++;
    if (e16 !== 1'b1 || b16 !== 1'b0 || e12 !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: err=%b busy=%b err12=%b required 1 0 1", e16, b16, e12);
    end
    @(negedge Clk);
    checks++;
    if (e16 !== 1'b0) begin
      errors++;
      $display("FAIL timeout_single: err=%b required 0", e16);
    end
    send_frame(8'h01, 8'h02);
    expect_frame("timeout_fresh");
    consume("timeout");
  endtask

  task automatic test_overrun;
    send_frame(8'h34, 8'h12);
    expect_frame("overrun_pre");
    drive_byte(8'h99, 1'b0);
    checks++;
    if (e16 !== 1'b1 || v16 !== 1'b1 || data16 !== 16'h1234) begin
      errors++;
      $display("FAIL overrun_pulse: err=%b valid=%b data=%h required 1 1 1234", e16, v16, data16);
    end
    @(negedge Clk);
    checks++;
    if (e16 !== 1'b0 || v16 !== 1'b1) begin
      errors++;
      $display("FAIL overrun_after: err=%b valid=%b required 0 1", e16, v16);
    end
    exp_q.push_back(16'h6677);
    drive_byte(8'h77, 1'b1);
    checks++;
    if (v16 !== 1'b0 || b16 !== 1'b1 || data16 !== 16'h0077) begin
      errors++;
      $display("FAIL overrun_restart: valid=%b busy=%b data=%h required 0 1 0077", v16, b16, data16);
    end
    drive_byte(8'h66, 1'b0);
`ifdef FRAME_CHKSUM_EN
    drive_byte(8'h77 ^ 8'h66, 1'b0);
`endif
    expect_frame("overrun_new");
    consume("overrun");
  endtask

  task automatic test_reset_mid;
    drive_byte(8'hAA, 1'b0);
    #2 Rst_n = 1'b0;
    #1;
    checks++;
    if ({v16, e16, b16} !== 3'b0 || data16 !== 16'h0 || data12 !== 12'h0) begin
      errors++;
      $display("FAIL reset_mid: v/e/b=%b%b%b data=%h/%h required 000 0/0", v16, e16, b16, data16, data12);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
    send_frame(8'hCD, 8'hAB);
    expect_frame("reset_mid");
    consume("reset_mid");
  endtask

  task automatic test_back_to_back;
    logic [7:0] b0, b1;
    for (int f = 0; f < 4; f++) begin
      b0 = 8'($urandom_range(0, 255));
      b1 = 8'($urandom_range(0, 255));
      send_frame(b0, b1);
      expect_frame("b2b");
      consume("b2b");
    end
  endtask

`ifdef FRAME_CHKSUM_EN
  task automatic test_chksum_bad;
    drive_byte(8'h34, 1'b0);
    drive_byte(8'h12, 1'b0);
    drive_byte(8'h00, 1'b0);
    checks++;
    if (e16 !== 1'b1 || v16 !== 1'b0 || b16 !== 1'b0) begin
      errors++;
      $display("FAIL chksum_bad: err=%b valid=%b busy=%b required 1 0 0", e16, v16, b16);
    end
    @(negedge Clk);
    checks++;
    if (e16 !== 1'b0 || v16 !== 1'b0) begin
      errors++;
      $display("FAIL chksum_after: err=%b valid=%b required 0 0", e16, v16);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_m12();
    test_timeout();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
`ifdef FRAME_CHKSUM_EN
    test_chksum_bad();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
